// File: rtl/fir_pkg.sv
// fir_pkg: shared FSM states and width helpers for the FIR MAC engine
package fir_pkg;
  typedef enum logic [1:0] {IDLE, PRIME, MAC, DONE} state_t;
  function automatic int addr_w(input int taps);
    return taps > 1 ? $clog2(taps) : 1;
  endfunction
  function automatic logic signed [63:0] sat_narrow(input logic signed [63:0] v, input int w);
    logic signed [63:0] hi, lo;
    hi = (64'sd1 <<< (w - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (w - 1));
    return v > hi ? hi : v < lo ? lo : v;
  endfunction
endpackage

// File: rtl/fir_mac_lane.sv
// fir_mac_lane: one channel accumulator with output shift; FIR_SAT_EN clips instead of wrapping
module fir_mac_lane import fir_pkg::*; #(
  parameter int DATA_W  = 16,
  parameter int COEF_W  = 16,
  parameter int ACC_W   = 40,
  parameter int FRAC_SH = 15
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     clear,
  input  logic                     enable,
  input  logic signed [DATA_W-1:0] sample,
  input  logic signed [COEF_W-1:0] coef,
  output logic        [DATA_W-1:0] result
);
  localparam int PW = DATA_W + COEF_W;
  logic signed [ACC_W-1:0] acc;
  logic signed [PW-1:0] prod;
  assign prod = sample * coef;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) acc <= '0;
    else if (clear) acc <= '0;
    else if (enable) acc <= acc + {{(ACC_W - PW){prod[PW-1]}}, prod};
`ifdef FIR_SAT_EN
  logic signed [ACC_W-1:0] shifted;
  assign shifted = acc >>> FRAC_SH;
  assign result = DATA_W'(sat_narrow(64'(shifted), DATA_W));
`else
  assign result = acc[FRAC_SH+DATA_W-1:FRAC_SH];
`endif
endmodule

// File: rtl/fir_mac_engine.sv
// fir_mac_engine: multi-channel FIR MAC sequencer driving external ROM/queue addresses
// Optional output saturation via FIR_SAT_EN (inside fir_mac_lane).
module fir_mac_engine import fir_pkg::*; #(
  parameter int NUM_CH  = 2,
  parameter int DATA_W  = 16,
  parameter int COEF_W  = 16,
  parameter int TAPS    = 1021,
  parameter int ACC_W   = 40,
  parameter int FRAC_SH = 15
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       start,
  output logic [addr_w(TAPS)-1:0]    coef_addr,
  output logic [addr_w(TAPS)-1:0]    rd_idx,
  input  logic [COEF_W-1:0]          coef_in,
  input  logic [NUM_CH*DATA_W-1:0]   smpl_in,
  output logic                       busy,
  output logic                       out_vld,
  output logic [NUM_CH*DATA_W-1:0]   smpl_out
);
  localparam int AW = addr_w(TAPS);
  localparam logic [AW-1:0] LAST = AW'(TAPS - 1);
  state_t state;
  logic start_q, edge_det;
  logic [AW-1:0] addr, k;
  logic [NUM_CH*DATA_W-1:0] res;
  assign edge_det = start & ~start_q;
  assign coef_addr = addr;
  assign rd_idx = addr;
  for (genvar c = 0; c < NUM_CH; c++) begin : g_lane
    fir_mac_lane #(.DATA_W(DATA_W), .COEF_W(COEF_W), .ACC_W(ACC_W), .FRAC_SH(FRAC_SH)) u_lane (
      .clk(clk),
      .rst_n(rst_n),
      .clear(edge_det),
      .enable(state == MAC),
      .sample(smpl_in[c*DATA_W +: DATA_W]),
      .coef(coef_in),
      .result(res[c*DATA_W +: DATA_W])
    );
  end
  // Any edge, even mid-run, restarts from PRIME; lanes clear on the same edge.
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      start_q <= 1'b0;
      addr <= '0;
      k <= '0;
      busy <= 1'b0;
      out_vld <= 1'b0;
      smpl_out <= '0;
    end else begin
      start_q <= start;
      out_vld <= 1'b0;
      if (edge_det) begin
        state <= PRIME;
        addr <= '0;
        busy <= 1'b1;
      end else
        case (state)
          PRIME: begin
            state <= MAC;
            addr <= AW'(1);
            k <= '0;
          end
          MAC: begin
            addr <= addr == LAST ? addr : addr + AW'(1);
            k <= k + AW'(1);
            if (k == LAST) begin
              state <= DONE;
              busy <= 1'b0;
            end
          end
          DONE: begin
            state <= IDLE;
            addr <= '0;
            out_vld <= 1'b1;
            smpl_out <= res;
          end
          default: ;
        endcase
    end
endmodule

// File: tb/tb_fir_mac_engine.sv
// tb_fir_mac_engine: TAPS=4 and TAPS=8 engines on a shared start, checked against a timeline model
module tb_fir_mac_engine;
  logic clk = 1'b0, rst_n = 1'b0, start = 1'b0;
  always #5 clk = ~clk;
  logic [15:0] rom [8];
  logic [15:0] smem [2][8];
  logic [15:0] coef4, coef8;
  logic [31:0] smpl4, smpl8, out4, out8;
  logic [1:0] addr4, idx4;
  logic [2:0] addr8, idx8;
  logic busy4, busy8, vld4, vld8;
  int compared = 0, mismatched = 0;
`ifdef FIR_SAT_EN
  localparam logic [31:0] NOM8 = 32'h7FFF7FFF, IND8 = 32'h80007FFF, OV4 = 32'h7FFF7FFF, OV8 = 32'h7FFF7FFF;
`else
  localparam logic [31:0] NOM8 = 32'h80008000, IND8 = 32'h80008000, OV4 = 32'hFFF8FFF8, OV8 = 32'hFFF0FFF0;
`endif
  localparam logic [39:0] M_ALL = '1, M_VO = 40'h80_FFFF_FFFF;
  fir_mac_engine #(.NUM_CH(2), .DATA_W(16), .COEF_W(16), .TAPS(4), .ACC_W(40), .FRAC_SH(15)) u4 (
    .clk(clk), .rst_n(rst_n), .start(start), .coef_addr(addr4), .rd_idx(idx4),
    .coef_in(coef4), .smpl_in(smpl4), .busy(busy4), .out_vld(vld4), .smpl_out(out4));
  fir_mac_engine #(.NUM_CH(2), .DATA_W(16), .COEF_W(16), .TAPS(8), .ACC_W(40), .FRAC_SH(15)) u8 (
    .clk(clk), .rst_n(rst_n), .start(start), .coef_addr(addr8), .rd_idx(idx8),
    .coef_in(coef8), .smpl_in(smpl8), .busy(busy8), .out_vld(vld8), .smpl_out(out8));
  // External ROM and sample queue, one-cycle read latency
  always @(posedge clk) begin
    coef4 <= rom[{1'b0, addr4}];
    smpl4 <= {smem[1][{1'b0, addr4}], smem[0][{1'b0, addr4}]};
    coef8 <= rom[addr8];
    smpl8 <= {smem[1][addr8], smem[0][addr8]};
  end
  function automatic int tp(input int i);
    return i != 0 ? 8 : 4;
  endfunction
  function automatic logic [15:0] narrow(input longint v);
`ifdef FIR_SAT_EN
    return v > 32767 ? 16'h7FFF : v < -32768 ? 16'h8000 : 16'(v);
`else
    return 16'(v);
`endif
  endfunction
  function automatic logic [31:0] fir_out(input int taps);
    logic [31:0] r;
    longint s;
    for (int c = 0; c < 2; c++) begin
      s = 0;
      for (int t = 0; t < taps; t++) s += longint'($signed(rom[t])) * longint'($signed(smem[c][t]));
      r[c*16 +: 16] = narrow(s >>> 15);
    end
    return r;
  endfunction
  // Model: j counts cycles since the last start edge; the run completes only if j reaches TAPS+3.
  int j [2] = '{1000, 1000};
  int nj;
  logic [31:0] exp_out [2] = '{32'h0, 32'h0};
  logic sp = 1'b0;
  always @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      sp <= 1'b0;
      j <= '{1000, 1000};
      exp_out <= '{32'h0, 32'h0};
    end else begin
      sp <= start;
      for (int i = 0; i < 2; i++) begin
        nj = (start && !sp) ? 1 : j[i] < 1000 ? j[i] + 1 : j[i];
        j[i] <= nj;
        if (nj == tp(i) + 3) exp_out[i] <= fir_out(tp(i));
      end
    end
  function automatic logic [39:0] pr(input logic v, input logic b, input logic [2:0] a, input logic [31:0] o);
    return {v, b, a, a, o};
  endfunction
  function automatic logic [39:0] expect_probe(input int i);
    int t, jj;
    logic [2:0] a;
    t = tp(i);
    jj = j[i];
    a = (jj >= 1 && jj <= t + 2) ? 3'((jj - 1 < t - 1) ? jj - 1 : t - 1) : 3'd0;
    return pr(jj == t + 3, jj >= 1 && jj <= t + 1, a, exp_out[i]);
  endfunction
  function automatic logic [39:0] act(input int i);
    return i != 0 ? {vld8, busy8, idx8, addr8, out8} : {vld4, busy4, 1'b0, idx4, 1'b0, addr4, out4};
  endfunction
  logic lit_req = 1'b0;
  int lit_i = 0;
  logic [39:0] lit_exp = '0, lit_mask = '0;
  string lit_name = "";
  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      compared++;
      if (act(i) !== expect_probe(i)) begin
        mismatched++;
        $display("FAIL model_u%0d t=%0t: got %h want %h", tp(i), $time, act(i), expect_probe(i));
      end
    end
    if (lit_req) begin
      compared++;
      if ((act(lit_i) & lit_mask) !== (lit_exp & lit_mask)) begin
        mismatched++;
        $display("FAIL %s: got %h want %h (mask %h)", lit_name, act(lit_i), lit_exp, lit_mask);
      end
    end
  end
  task automatic tick(input int n);
    repeat (n) begin
      @(negedge clk);
      #1;
    end
  endtask
  task automatic lit(input int i, input logic [39:0] e, input logic [39:0] m, input string nm);
    lit_i = i;
    lit_exp = e;
    lit_mask = m;
    lit_name = nm;
    lit_req = 1'b1;
    @(negedge clk);
    #1;
    lit_req = 1'b0;
  endtask
  task automatic fill(input logic [15:0] c, input logic [15:0] a, input logic [15:0] b);
    for (int t = 0; t < 8; t++) begin
      rom[t] = c;
      smem[0][t] = a;
      smem[1][t] = b;
    end
  endtask
  initial begin
    fill(16'h4000, 16'h2000, 16'h2000);
    tick(2);
    lit(0, '0, M_ALL, "reset_u4");
    lit(1, '0, M_ALL, "reset_u8");
    rst_n = 1'b1;
    tick(2);
    start = 1'b1;
    for (int k = 1; k <= 7; k++)
      lit(0, pr(k == 7, k <= 5, 3'(k == 7 ? 0 : k > 4 ? 3 : k - 1), k == 7 ? 32'h40004000 : 32'h0), M_ALL, "nominal_addr_u4");
    tick(3);
    lit(1, pr(1'b1, 1'b0, 3'd0, NOM8), M_ALL, "nominal_u8");
    start = 1'b0;
    tick(2);
    fill(16'h4000, 16'h2000, 16'hE000);
    start = 1'b1;
    tick(6);
    lit(0, pr(1'b1, 1'b0, 3'd0, 32'hC0004000), M_ALL, "indep_u4");
    tick(3);
    lit(1, pr(1'b1, 1'b0, 3'd0, IND8), M_ALL, "indep_u8");
    start = 1'b0;
    tick(2);
    fill(16'h7FFF, 16'h7FFF, 16'h7FFF);
    start = 1'b1;
    tick(6);
    lit(0, pr(1'b1, 1'b0, 3'd0, OV4), M_ALL, "overflow_u4");
    tick(3);
    lit(1, pr(1'b1, 1'b0, 3'd0, OV8), M_ALL, "overflow_u8");
    start = 1'b0;
    tick(2);
    for (int t = 0; t < 8; t++) begin
      rom[t] = 16'(32'h0800 * (t + 1));
      smem[0][t] = 16'h1000;
      smem[1][t] = 16'(-(256 * (t + 1)));
    end
    start = 1'b1;
    tick(1);
    start = 1'b0;
    tick(4);
    start = 1'b1;
    tick(5);
    lit(1, pr(1'b0, 1'b0, 3'd0, OV8), M_VO, "restart_hold_u8");
    lit(0, pr(1'b1, 1'b0, 3'd0, 32'hFE200A00), M_ALL, "restart_u4");
    tick(3);
    lit(1, pr(1'b1, 1'b0, 3'd0, 32'hF3402400), M_ALL, "restart_u8");
    start = 1'b0;
    tick(2);
    start = 1'b1;
    tick(10);
    lit(1, pr(1'b1, 1'b0, 3'd0, 32'hF3402400), M_ALL, "held_u8");
    tick(28);
    lit(1, pr(1'b0, 1'b0, 3'd0, 32'hF3402400), M_ALL, "held_idle_u8");
    start = 1'b0;
    tick(2);
    start = 1'b1;
    tick(3);
    rst_n = 1'b0;
    start = 1'b0;
    lit(0, '0, M_ALL, "reset_mid_u4");
    lit(1, '0, M_ALL, "reset_mid_u8");
    rst_n = 1'b1;
    tick(15);
    lit(0, '0, M_ALL, "post_reset_u4");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
